// File: rtl/fifo_flagged.sv
// Single-clock FIFO with an occupancy count, almost-full/almost-empty flags and
// sticky overflow/underflow error flags. The read port is either registered
// (standard mode) or first-word-fall-through, chosen by the FWFT parameter.
// All status flags come from the registered count, so each one changes in the
// cycle after the edge that accepted the push or pop.
module fifo_flagged #(
    parameter int ADDR_WIDTH    = 3,
    parameter int DATA_WIDTH    = 8,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

    // Reject parameter sets that would make the flags meaningless.
    if (ADDR_WIDTH < 1) begin : g_chk_addr
        $error("fifo_flagged: ADDR_WIDTH must be >= 1");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_chk_afull
        $error("fifo_flagged: AFULL_THRESH must be in 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_chk_aempty
        $error("fifo_flagged: AEMPTY_THRESH must be in 0..DEPTH-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_chk_fwft
        $error("fifo_flagged: FWFT must be 0 or 1");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic push_ok;
    logic pop_ok;
    logic ovf_event;
    logic udf_event;

    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A pop frees a slot in the same edge, so a push into a full FIFO is
    // accepted only when it is paired with a pop that is itself accepted.
    assign pop_ok    = pop & ~empty;
    assign push_ok   = push & (~full | pop_ok);
    assign ovf_event = push & ~push_ok;
    assign udf_event = pop & empty;

    // Next-state for the pointers, the count and the sticky error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A new error in the clearing cycle must not be lost, so set wins.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (ovf_event) begin
            overflow_d = 1'b1;
        end
        if (udf_event) begin
            underflow_d = 1'b1;
        end
    end

    // Control state register; reset drops any push or pop in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is left unreset; the count alone decides which slots are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Show the head word while anything is stored. A word written into an
        // empty FIFO appears only once the count has gone non-zero, so the
        // write and the read of the head slot can never race.
        always_comb begin
            rd_data = '0;
            if (!empty) begin
                rd_data = mem_q[rd_ptr_q];
            end
        end
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

        // Registered read: load the head word only on an accepted pop.
        always_comb begin
            rd_data_d = rd_data_q;
            if (pop_ok) begin
                rd_data_d = mem_q[rd_ptr_q];
            end
        end

        // Read data register; holds its value when a pop is rejected.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q <= '0;
            end else begin
                rd_data_q <= rd_data_d;
            end
        end

        assign rd_data = rd_data_q;
    end

endmodule

// File: tb/tb_fifo_flagged.sv
// Bench for fifo_flagged: one standard-read and one FWFT instance share the same
// stimulus. A queue-based reference model predicts the count, the flags and the
// read data of both instances.
module tb_fifo_flagged;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] wr_data = '0;

    logic [7:0] s_rd, f_rd;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [3:0] s_cnt, f_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    logic [7:0] m_std_rd = '0;

    always #5 clk = ~clk;

    fifo_flagged #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .FWFT(0),
                   .AFULL_THRESH(6), .AEMPTY_THRESH(1)) u_std (
        .clk(clk), .rst_n(rst_n), .push(push), .wr_data(wr_data), .pop(pop),
        .rd_data(s_rd), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_cnt), .overflow(s_ovf), .underflow(s_udf),
        .clr_err(clr_err));

    fifo_flagged #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .FWFT(1),
                   .AFULL_THRESH(6), .AEMPTY_THRESH(1)) u_fw (
        .clk(clk), .rst_n(rst_n), .push(push), .wr_data(wr_data), .pop(pop),
        .rd_data(f_rd), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_cnt), .overflow(f_ovf), .underflow(f_udf),
        .clr_err(clr_err));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        logic [7:0] head;
        n = q.size();
        head = (n > 0) ? q[0] : 8'd0;
        check("std.count", 32'(s_cnt), 32'(n));
        check("std.full", 32'(s_full), 32'(n == 8));
        check("std.empty", 32'(s_empty), 32'(n == 0));
        check("std.afull", 32'(s_af), 32'(n >= 6));
        check("std.aempty", 32'(s_ae), 32'(n <= 1));
        check("std.ovf", 32'(s_ovf), 32'(m_ovf));
        check("std.udf", 32'(s_udf), 32'(m_udf));
        check("std.rd_data", 32'(s_rd), 32'(m_std_rd));
        check("fw.count", 32'(f_cnt), 32'(n));
        check("fw.full", 32'(f_full), 32'(n == 8));
        check("fw.empty", 32'(f_empty), 32'(n == 0));
        check("fw.afull", 32'(f_af), 32'(n >= 6));
        check("fw.aempty", 32'(f_ae), 32'(n <= 1));
        check("fw.ovf", 32'(f_ovf), 32'(m_ovf));
        check("fw.udf", 32'(f_udf), 32'(m_udf));
        check("fw.rd_data", 32'(f_rd), 32'(head));
    endtask

    // One clock of stimulus: apply inputs, advance the model at the edge,
    // then compare shortly after the edge.
    task automatic step(input logic ps, input logic [7:0] d, input logic pp, input logic ce);
        bit pop_ok, push_ok, new_ovf, new_udf;
        push = ps; wr_data = d; pop = pp; clr_err = ce;
        @(posedge clk);
        pop_ok  = pp && (q.size() > 0);
        push_ok = ps && ((q.size() < 8) || pop_ok);
        new_ovf = ps && !push_ok;
        new_udf = pp && (q.size() == 0);
        if (pop_ok) m_std_rd = q.pop_front();
        if (push_ok) q.push_back(d);
        m_ovf = (m_ovf && !ce) || new_ovf;
        m_udf = (m_udf && !ce) || new_udf;
        #1;
        check_all();
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_std_rd = '0;
    endtask

    // Assert reset between edges with a push pending, hold it across an edge,
    // then release on a falling edge.
    task automatic mid_reset();
        push = 1'b1; wr_data = 8'hEE;
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        push = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full with 1..8, then a push into a full FIFO, then clear.
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'd99, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b1);

        // Drain in order, then a pop from empty; read data must hold.
        for (int i = 0; i < 9; i++) step(1'b0, 8'd0, 1'b1, 1'b0);
        // Clear in the same cycle as a new underflow: set wins.
        step(1'b0, 8'd0, 1'b1, 1'b1);
        step(1'b0, 8'd0, 1'b0, 1'b1);

        // Pointer wrap.
        for (int i = 100; i <= 104; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 1'b1, 1'b0);
        for (int i = 105; i <= 107; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'd0, 1'b1, 1'b0);

        // Push and pop together on a full FIFO, then drain.
        for (int i = 10; i < 18; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'd200, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 8'd0, 1'b1, 1'b0);

        // Push and pop together on an empty FIFO: push lands, pop flags underflow.
        step(1'b1, 8'd55, 1'b1, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b1);

        // FWFT head shown without a pop, then consumed.
        step(1'b1, 8'd42, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0);

        // Reset in the middle of filling three words.
        for (int i = 1; i <= 2; i++) step(1'b1, 8'(60 + i), 1'b0, 1'b0);
        mid_reset();
        step(1'b1, 8'd77, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0);

        // Randomised traffic, with phases biased toward filling and draining.
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = ((i / 200) % 2 == 0) ? 70 : 30;
            step(($urandom_range(0, 99) < bias), 8'($urandom),
                 ($urandom_range(0, 99) < (100 - bias)),
                 ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 499) == 0) mid_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
